// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing generator: phase encodings, phase
// sequencing helper and the black pixel constant.
package vtg_pkg;

  localparam logic [1:0] PH_ACT = 2'd0;
  localparam logic [1:0] PH_FP  = 2'd1;
  localparam logic [1:0] PH_SYN = 2'd2;
  localparam logic [1:0] PH_BP  = 2'd3;

  typedef enum logic [1:0] {
    ST_ACT = PH_ACT,
    ST_FP  = PH_FP,
    ST_SYN = PH_SYN,
    ST_BP  = PH_BP
  } phase_t;

  localparam logic [7:0] BLACK = 8'h00;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ST_ACT:  return ST_FP;
      ST_FP:   return ST_SYN;
      ST_SYN:  return ST_BP;
      default: return ST_ACT;
    endcase
  endfunction

endpackage

// File: rtl/vtg_pixel_fifo.sv
// Synchronous pixel FIFO with a flush that empties it in one clock.
// Push and pop may coincide; push when full and pop when empty are ignored.
module vtg_pixel_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_L);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Fixed-timing video sync/blank generator streaming fetcher pixels through a FIFO.
// Optional per-frame underflow counters enabled by VIDEO_TIMING_UFCNT_EN.
module video_timing_gen import vtg_pkg::*; #(
  parameter int   COLOR_DEPTH = 6,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 200,
  parameter int   V_FP        = 1,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 1,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   FIFO_DEPTH  = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce_pix,
  input  logic [3*COLOR_DEPTH-1:0] pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     line_start,
  output logic                     frame_start,
  output logic [COLOR_DEPTH-1:0]   R,
  output logic [COLOR_DEPTH-1:0]   G,
  output logic [COLOR_DEPTH-1:0]   B,
  output logic                     HSync,
  output logic                     VSync,
  output logic                     HBlank,
  output logic                     VBlank,
`ifdef VIDEO_TIMING_UFCNT_EN
  output logic [7:0]               ufcnt,
  output logic [7:0]               ufcnt_last,
`endif
  output logic                     underflow
);

  localparam int PW      = 3*COLOR_DEPTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PIX_BLACK = {3{BLACK[COLOR_DEPTH-1:0]}};
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);

  phase_t        hph, hph_n, vph, vph_n;
  logic [HW-1:0] hcnt, hcnt_n, h_end;
  logic [VW-1:0] vcnt, vcnt_n, v_end;
  logic          line_end, line_ev, frame_ev, flush;
  logic          active, pop, starve;

  logic [PW-1:0] fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic [PW-1:0] rgb_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hph  <= ST_ACT;
      hcnt <= '0;
      vph  <= ST_ACT;
      vcnt <= '0;
    end else begin
      hph  <= hph_n;
      hcnt <= hcnt_n;
      vph  <= vph_n;
      vcnt <= vcnt_n;
    end
  end

  always_comb begin
    hph_n  = hph;
    hcnt_n = hcnt;
    vph_n  = vph;
    vcnt_n = vcnt;
    case (hph)
      ST_ACT:  h_end = HW'(H_ACTIVE - 1);
      ST_FP:   h_end = HW'(H_FP - 1);
      ST_SYN:  h_end = HW'(H_SYNC - 1);
      default: h_end = HW'(H_BP - 1);
    endcase
    case (vph)
      ST_ACT:  v_end = VW'(V_ACTIVE - 1);
      ST_FP:   v_end = VW'(V_FP - 1);
      ST_SYN:  v_end = VW'(V_SYNC - 1);
      default: v_end = VW'(V_BP - 1);
    endcase
    line_end = ce_pix & (hcnt == h_end) & (hph == ST_BP);
    if (ce_pix) begin
      if (hcnt == h_end) begin
        hcnt_n = '0;
        hph_n  = next_phase(hph);
      end else begin
        hcnt_n = hcnt + 1'b1;
      end
    end
    if (line_end) begin
      if (vcnt == v_end) begin
        vcnt_n = '0;
        vph_n  = next_phase(vph);
      end else begin
        vcnt_n = vcnt + 1'b1;
      end
    end
    line_ev  = line_end & (vph_n == ST_ACT);
    frame_ev = line_end & (vcnt == v_end) & (vph == ST_BP);
    flush    = line_end & (vcnt == v_end) & (vph == ST_FP);
  end

  assign active    = (hph == ST_ACT) & (vph == ST_ACT);
  assign pop       = ce_pix & active & ~fifo_empty;
  assign starve    = ce_pix & active & fifo_empty;
  // Ready drops on the flush clock so no handshake completes into a FIFO being cleared.
  assign pix_ready = ~reset & ~fifo_full & ~flush;

  vtg_pixel_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (pix_valid & pix_ready),
    .pop   (pop),
    .flush (flush),
    .din   (pix_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset) assert (fifo_count <= DEPTH_L);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      HBlank      <= 1'b1;
      VBlank      <= 1'b1;
      HSync       <= ~SYNC_POL;
      VSync       <= ~SYNC_POL;
      rgb_q       <= PIX_BLACK;
      underflow   <= 1'b0;
    end else begin
      line_start  <= line_ev;
      frame_start <= frame_ev;
      if (ce_pix) begin
        HBlank    <= (hph != ST_ACT);
        VBlank    <= (vph != ST_ACT);
        HSync     <= (hph == ST_SYN) ? SYNC_POL : ~SYNC_POL;
        VSync     <= (vph == ST_SYN) ? SYNC_POL : ~SYNC_POL;
        rgb_q     <= (active & ~fifo_empty) ? fifo_dout : PIX_BLACK;
        underflow <= frame_ev ? 1'b0 : (underflow | starve);
      end
    end
  end

  assign {R, G, B} = rgb_q;

`ifdef VIDEO_TIMING_UFCNT_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ufcnt      <= 8'd0;
      ufcnt_last <= 8'd0;
    end else if (frame_ev) begin
      ufcnt_last <= ufcnt;
      ufcnt      <= 8'd0;
    end else if (starve && ufcnt != 8'hFF) begin
      ufcnt <= ufcnt + 8'd1;
    end
  end
`endif

endmodule
